// File: rtl/control_sequencer.sv
// Hardwired control unit for Datapath2: fetch (T0-T2), opcode decode and
// per-instruction execute states (T3-T7), with HALT via opcode or Stop.
module control_sequencer #(
    parameter logic [4:0] ALU_ADD   = 5'd2,
    parameter logic [4:0] ALU_SUB   = 5'd3,
    parameter logic [4:0] ALU_AND   = 5'd4,
    parameter logic [4:0] ALU_OR    = 5'd5,
    parameter logic [4:0] ALU_INCPC = 5'd12
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] IR,
    input  logic        Stop,
    output logic        PCout,
    output logic        Zlowout,
    output logic        MDRout,
    output logic        BAout,
    output logic        Rout,
    output logic        Cout,
    output logic        MARin,
    output logic        Zin,
    output logic        PCin,
    output logic        MDRin,
    output logic        IRin,
    output logic        Yin,
    output logic        Rin,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Read,
    output logic        Write,
    output logic [4:0]  ALU_Control,
    output logic        Run
);

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_HALT = 5'b11011;

    typedef enum logic [3:0] {
        S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_t;

    state_t     state_q, state_d;
    logic [4:0] opcode_q, opcode_d;
    state_t     done_next;
    logic       ir_unused;

    // Operand fields are consumed by the datapath's register-select logic, not here.
    assign ir_unused = ^IR[26:0];

    function automatic logic has_execute(input logic [4:0] op);
        case (op)
            OP_LD, OP_LDI, OP_ST, OP_ADD, OP_SUB,
            OP_AND, OP_OR, OP_ADDI: has_execute = 1'b1;
            default:                has_execute = 1'b0;
        endcase
    endfunction

    // State and latched opcode registers; clr aborts everything at once.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q  <= S_RESET;
            opcode_q <= '0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
        end
    end

    // Next-state logic; Stop is only honoured on edges that would return to T0.
    always_comb begin
        state_d   = state_q;
        opcode_d  = opcode_q;
        done_next = Stop ? S_HALT : S_T0;
        case (state_q)
            S_RESET: state_d = S_T0;
            S_T0:    state_d = S_T1;
            S_T1:    state_d = S_T2;
            S_T2: begin
                opcode_d = IR[31:27];
                if (IR[31:27] == OP_HALT)        state_d = S_HALT;
                else if (has_execute(IR[31:27])) state_d = S_T3;
                else                             state_d = done_next;
            end
            S_T3:    state_d = S_T4;
            S_T4:    state_d = S_T5;
            S_T5:    state_d = (opcode_q == OP_LD || opcode_q == OP_ST) ? S_T6 : done_next;
            S_T6:    state_d = S_T7;
            S_T7:    state_d = done_next;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_RESET;
        endcase
    end

    // Control outputs decoded from the current state and latched opcode.
    always_comb begin
        PCout = 1'b0; Zlowout = 1'b0; MDRout = 1'b0; BAout = 1'b0;
        Rout = 1'b0; Cout = 1'b0; MARin = 1'b0; Zin = 1'b0; PCin = 1'b0;
        MDRin = 1'b0; IRin = 1'b0; Yin = 1'b0; Rin = 1'b0;
        Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Read = 1'b0; Write = 1'b0;
        ALU_Control = '0;
        Run = (state_q != S_RESET) && (state_q != S_HALT);
        case (state_q)
            S_T0: begin
                PCout = 1'b1; MARin = 1'b1; Zin = 1'b1; ALU_Control = ALU_INCPC;
            end
            S_T1: begin
                Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
            end
            S_T2: begin
                MDRout = 1'b1; IRin = 1'b1;
            end
            S_T3: begin
                Grb = 1'b1; Yin = 1'b1;
                if (opcode_q == OP_LD || opcode_q == OP_LDI || opcode_q == OP_ST) BAout = 1'b1;
                else                                                              Rout  = 1'b1;
            end
            S_T4: begin
                Zin = 1'b1;
                case (opcode_q)
                    OP_ADD:  begin Grc = 1'b1; Rout = 1'b1; ALU_Control = ALU_ADD; end
                    OP_SUB:  begin Grc = 1'b1; Rout = 1'b1; ALU_Control = ALU_SUB; end
                    OP_AND:  begin Grc = 1'b1; Rout = 1'b1; ALU_Control = ALU_AND; end
                    OP_OR:   begin Grc = 1'b1; Rout = 1'b1; ALU_Control = ALU_OR;  end
                    default: begin Cout = 1'b1; ALU_Control = ALU_ADD; end
                endcase
            end
            S_T5: begin
                Zlowout = 1'b1;
                if (opcode_q == OP_LD || opcode_q == OP_ST) begin
                    MARin = 1'b1;
                end else begin
                    Gra = 1'b1; Rin = 1'b1;
                end
            end
            S_T6: begin
                MDRin = 1'b1;
                if (opcode_q == OP_ST) begin
                    Gra = 1'b1; Rout = 1'b1;
                end else begin
                    Read = 1'b1;
                end
            end
            S_T7: begin
                if (opcode_q == OP_ST) begin
                    Write = 1'b1;
                end else begin
                    MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: a behavioural Datapath2 model
// reacts to the strobes, expected strobe words come from per-instruction
// tables, and architectural results are predicted with plain arithmetic.
module tb_control_sequencer;

    logic        clk = 1'b0;
    logic        clr, Stop;
    logic [31:0] IR;
    logic PCout, Zlowout, MDRout, BAout, Rout, Cout, MARin, Zin, PCin;
    logic MDRin, IRin, Yin, Rin, Gra, Grb, Grc, Read, Write, Run;
    logic [4:0] ALU_Control;

    int checks = 0;
    int errors = 0;

    control_sequencer #(
        .ALU_ADD(5'd2), .ALU_SUB(5'd3), .ALU_AND(5'd4), .ALU_OR(5'd5), .ALU_INCPC(5'd12)
    ) dut (
        .clk(clk), .clr(clr), .IR(IR), .Stop(Stop),
        .PCout(PCout), .Zlowout(Zlowout), .MDRout(MDRout), .BAout(BAout),
        .Rout(Rout), .Cout(Cout), .MARin(MARin), .Zin(Zin), .PCin(PCin),
        .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .Rin(Rin),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Read(Read), .Write(Write),
        .ALU_Control(ALU_Control), .Run(Run)
    );

    always #5 clk = ~clk;

    // Strobe word: {PCout..Write, ALU_Control, Run}
    logic [23:0] obs;
    assign obs = {PCout, Zlowout, MDRout, BAout, Rout, Cout, MARin, Zin, PCin,
                  MDRin, IRin, Yin, Rin, Gra, Grb, Grc, Read, Write, ALU_Control, Run};

    localparam logic [23:0] W_PCOUT = 24'h800000, W_ZLOW  = 24'h400000, W_MDROUT = 24'h200000;
    localparam logic [23:0] W_BAOUT = 24'h100000, W_ROUT  = 24'h080000, W_COUT   = 24'h040000;
    localparam logic [23:0] W_MARIN = 24'h020000, W_ZIN   = 24'h010000, W_PCIN   = 24'h008000;
    localparam logic [23:0] W_MDRIN = 24'h004000, W_IRIN  = 24'h002000, W_YIN    = 24'h001000;
    localparam logic [23:0] W_RIN   = 24'h000800, W_GRA   = 24'h000400, W_GRB    = 24'h000200;
    localparam logic [23:0] W_GRC   = 24'h000100, W_READ  = 24'h000080, W_WRITE  = 24'h000040;
    localparam logic [23:0] W_RUN   = 24'h000001;

    function automatic logic [23:0] alu(input logic [4:0] code);
        return {18'b0, code, 1'b0};
    endfunction

    // Behavioural datapath state
    logic [31:0] mem [256];
    logic [31:0] regs [16];
    logic [31:0] pc, mdr, y, z;
    logic [7:0]  mar;
    logic [23:0] exp_q [$];

    // The datapath model updates on the falling edge, so IR already holds the
    // newly fetched word when the sequencer decodes it on the T2->T3 edge.
    task automatic dp_update();
        logic [31:0] bus, c, aluv;
        logic [3:0]  sel;
        sel = Gra ? IR[26:23] : Grb ? IR[22:19] : Grc ? IR[18:15] : 4'd0;
        c   = {{13{IR[18]}}, IR[18:0]};
        bus = '0;
        if (PCout)        bus = pc;
        else if (Zlowout) bus = z;
        else if (MDRout)  bus = mdr;
        else if (BAout)   bus = (sel == 4'd0) ? 32'd0 : regs[sel];
        else if (Rout)    bus = regs[sel];
        else if (Cout)    bus = c;
        case (ALU_Control)
            5'd2:    aluv = y + bus;
            5'd3:    aluv = y - bus;
            5'd4:    aluv = y & bus;
            5'd5:    aluv = y | bus;
            5'd12:   aluv = bus + 32'd1;
            default: aluv = z;
        endcase
        if (Write) mem[mar] = mdr;
        if (MDRin) mdr = Read ? mem[mar] : bus;
        if (Zin)   z = aluv;
        if (Yin)   y = bus;
        if (MARin) mar = bus[7:0];
        if (PCin)  pc = bus;
        if (IRin)  IR = bus;
        if (Rin)   regs[sel] = bus;
    endtask

    task automatic check_word(input logic [23:0] exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_val(input logic [31:0] got, input logic [31:0] exp, input string tag);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // One cycle: sample strobes mid-cycle, compare, then let the datapath react.
    task automatic step(input logic [23:0] exp, input string tag);
        @(negedge clk);
        check_word(exp, tag);
        dp_update();
    endtask

    // Expected strobe words for a whole instruction, straight from the
    // instruction tables.
    task automatic build_exp(input logic [4:0] op);
        exp_q.delete();
        exp_q.push_back(W_PCOUT | W_MARIN | W_ZIN | alu(5'd12) | W_RUN);
        exp_q.push_back(W_ZLOW | W_PCIN | W_READ | W_MDRIN | W_RUN);
        exp_q.push_back(W_MDROUT | W_IRIN | W_RUN);
        case (op)
            5'd0, 5'd1, 5'd2: begin
                exp_q.push_back(W_GRB | W_BAOUT | W_YIN | W_RUN);
                exp_q.push_back(W_COUT | W_ZIN | alu(5'd2) | W_RUN);
                if (op == 5'd1) begin
                    exp_q.push_back(W_ZLOW | W_GRA | W_RIN | W_RUN);
                end else begin
                    exp_q.push_back(W_ZLOW | W_MARIN | W_RUN);
                    if (op == 5'd0) begin
                        exp_q.push_back(W_READ | W_MDRIN | W_RUN);
                        exp_q.push_back(W_MDROUT | W_GRA | W_RIN | W_RUN);
                    end else begin
                        exp_q.push_back(W_GRA | W_ROUT | W_MDRIN | W_RUN);
                        exp_q.push_back(W_WRITE | W_RUN);
                    end
                end
            end
            5'd3, 5'd4, 5'd5, 5'd6: begin
                exp_q.push_back(W_GRB | W_ROUT | W_YIN | W_RUN);
                exp_q.push_back(W_GRC | W_ROUT | W_ZIN | alu(op - 5'd1) | W_RUN);
                exp_q.push_back(W_ZLOW | W_GRA | W_RIN | W_RUN);
            end
            5'd12: begin
                exp_q.push_back(W_GRB | W_ROUT | W_YIN | W_RUN);
                exp_q.push_back(W_COUT | W_ZIN | alu(5'd2) | W_RUN);
                exp_q.push_back(W_ZLOW | W_GRA | W_RIN | W_RUN);
            end
            default: ;
        endcase
    endtask

    // Runs the instruction at mem[pc]; raises Stop after step index stop_at.
    task automatic run_instr(input string name, input int stop_at);
        logic [31:0] ins, c, base, exp_val, exp_pc;
        logic [3:0]  ra, rb, rc;
        logic [7:0]  addr;
        int          kind;  // 0 none, 1 register, 2 memory
        ins  = mem[pc[7:0]];
        ra   = ins[26:23]; rb = ins[22:19]; rc = ins[18:15];
        c    = {{13{ins[18]}}, ins[18:0]};
        base = (rb == 4'd0) ? 32'd0 : regs[rb];
        addr = 8'(base + c);
        exp_pc = pc + 32'd1;
        kind = 1; exp_val = '0;
        case (ins[31:27])
            5'd0:  exp_val = mem[addr];
            5'd1:  exp_val = base + c;
            5'd2:  begin kind = 2; exp_val = regs[ra]; end
            5'd3:  exp_val = regs[rb] + regs[rc];
            5'd4:  exp_val = regs[rb] - regs[rc];
            5'd5:  exp_val = regs[rb] & regs[rc];
            5'd6:  exp_val = regs[rb] | regs[rc];
            5'd12: exp_val = regs[rb] + c;
            default: kind = 0;
        endcase
        build_exp(ins[31:27]);
        foreach (exp_q[i]) begin
            step(exp_q[i], $sformatf("%s T%0d", name, i));
            if (i == stop_at) Stop = 1'b1;
        end
        check_val(pc, exp_pc, {name, " pc"});
        if (kind == 1) check_val(regs[ra], exp_val, {name, " reg"});
        if (kind == 2) check_val(mem[addr], exp_val, {name, " mem"});
    endtask

    task automatic do_reset();
        clr  = 1'b1;
        Stop = 1'b0;
        pc   = '0;
        #1;
        check_word('0, "reset async");
        @(negedge clk);
        check_word('0, "reset held");
        for (int i = 0; i < 256; i++) mem[i] = 32'hD000_0000;  // nop fill
        clr = 1'b0;
    endtask

    task automatic halted(input int n, input string name);
        for (int i = 0; i < n; i++) step('0, $sformatf("%s halted %0d", name, i));
    endtask

    initial begin
        logic [4:0] op;
        logic [3:0] ra, rb, rc;
        IR = '0; Stop = 1'b0; clr = 1'b1;
        mdr = '0; y = '0; z = '0; mar = '0;
        for (int i = 0; i < 16; i++) regs[i] = '0;

        // 1: ld R1, 0x75 followed by nop (checks the 8-cycle length)
        do_reset();
        mem[0] = 32'h0080_0075; mem[8'h75] = 32'd9;
        run_instr("ld", -1);
        run_instr("nop_after_ld", -1);

        // 2: st R1, 0x75
        do_reset();
        regs[1] = 32'h1234; mem[0] = 32'h1080_0075;
        run_instr("st", -1);
        run_instr("nop_after_st", -1);

        // 3: add R3,R1,R2
        do_reset();
        regs[1] = 32'd5; regs[2] = 32'd7; mem[0] = 32'h1989_0000;
        run_instr("add", -1);
        check_val(regs[3], 32'd12, "add R3 value");
        run_instr("nop_after_add", -1);

        // 4: unknown opcode then nop
        do_reset();
        mem[0] = 32'hF800_0000;
        run_instr("unknown", -1);
        run_instr("nop", -1);

        // 5: Stop raised during T4 of ld; the ld completes, then HALT
        do_reset();
        mem[0] = 32'h0080_0075; mem[8'h75] = 32'd9; regs[1] = '0;
        run_instr("ld_stop", 4);
        halted(20, "stop");

        // 6: clr mid-T6 of st aborts it; Write never asserts
        do_reset();
        regs[1] = 32'h5555; mem[0] = 32'h1080_0075; mem[8'h75] = 32'hAAAA;
        build_exp(5'd2);
        for (int i = 0; i < 7; i++) step(exp_q[i], $sformatf("st_abort T%0d", i));
        #2 clr = 1'b1;
        pc = '0;
        #1 check_word('0, "clr mid-T6");
        @(posedge clk);
        #1 check_word('0, "clr held");
        @(negedge clk);
        clr = 1'b0;
        step(exp_q[0], "restart T0");
        step(exp_q[1], "restart T1");
        check_val(mem[8'h75], 32'hAAAA, "aborted st mem");

        // Random program ending in halt
        do_reset();
        for (int i = 0; i < 16; i++) regs[i] = $urandom;
        for (int i = 128; i < 256; i++) mem[i] = $urandom;
        for (int i = 0; i < 40; i++) begin
            ra = 4'($urandom); rb = 4'($urandom); rc = 4'($urandom);
            case ($urandom_range(0, 9))
                0: op = 5'd0;
                1: op = 5'd1;
                2: op = 5'd2;
                3: op = 5'd3;
                4: op = 5'd4;
                5: op = 5'd5;
                6: op = 5'd6;
                7: op = 5'd12;
                8: op = 5'd26;
                default: op = ($urandom_range(0, 1) == 0) ? 5'd9 : 5'd31;
            endcase
            if (op == 5'd0 || op == 5'd2)
                mem[i] = {op, ra, 4'd0, 11'd0, 1'b1, 7'($urandom)};
            else if (op == 5'd1 || op == 5'd12)
                mem[i] = {op, ra, rb, 19'($urandom)};
            else
                mem[i] = {op, ra, rb, rc, 15'($urandom)};
        end
        mem[40] = 32'hD800_0000;
        for (int i = 0; i <= 40; i++) run_instr($sformatf("rnd%0d", i), -1);
        halted(3, "halt_op");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Hardwired control unit that sits directly upstream of Datapath2 and drives all of its control inputs.
- Replaces the bench-driven control sequence for each instruction.
- Runs the fetch sequence T0–T2, decodes IR[31:27], then steps through the per-instruction execute states T3–T7 before returning to T0.
- Supports the ld, ldi, st, add, sub, and, or, addi, nop and halt instructions, plus an external Stop request.

Parameters:
ALU_ADD, 5'd2, ALU_Control code for add
ALU_SUB, 5'd3, ALU_Control code for subtract
ALU_AND, 5'd4, ALU_Control code for and
ALU_OR, 5'd5, ALU_Control code for or
ALU_INCPC, 5'd12, ALU_Control code for PC+1

Ports:
clk  in  1  system clock, rising edge
clr  in  1  reset, asynchronous, active-high
IR  in  32  instruction register contents from the datapath; opcode is IR[31:27]
Stop  in  1  external halt request, level-sensitive
PCout, Zlowout, MDRout, BAout, Rout, Cout  out  1 each  bus drive enables
MARin, Zin, PCin, MDRin, IRin, Yin, Rin  out  1 each  register load enables
Gra, Grb, Grc  out  1 each  register-select strobes
Read, Write  out  1 each  memory strobes
ALU_Control  out  5  ALU operation code
Run  out  1  high while executing; low in RESET and HALT

Behaviour:
- Interface: one clock, clk; reset clr is asynchronous and active-high.
- State register updates on posedge clk; each state lasts exactly one cycle.
- Outputs decode combinationally from the current state, plus the latched opcode in T3–T7. No output may glitch outside state changes.
- clr=1 forces the RESET state immediately, regardless of the clock. In RESET every output is 0, ALU_Control=0 and Run=0.
- First posedge after clr falls: RESET→T0. clr asserted mid-instruction aborts the instruction with no further strobes.
- Fetch sequence:
  - T0: PCout, MARin, Zin, ALU_Control=ALU_INCPC.
  - T1: Zlowout, PCin, Read, MDRin.
  - T2: MDRout, IRin.
- Opcode latch: IR[31:27] is captured into an internal opcode register on the T2→T3 edge. Execute states use only the latched copy.
- Any signal not listed for a state is 0. ALU_Control is 0 except in states that name a code.
- Opcodes: ld=00000, ldi=00001, st=00010, add=00011, sub=00100, and=00101, or=00110, addi=01100, nop=11010, halt=11011. Any other opcode executes as nop.
- ld:
  - T3: Grb, BAout, Yin.
  - T4: Cout, Zin, ALU_ADD.
  - T5: Zlowout, MARin.
  - T6: Read, MDRin.
  - T7: MDRout, Gra, Rin.
  - Then →T0.
- ldi: T3 and T4 as for ld; T5: Zlowout, Gra, Rin; then →T0.
- st:
  - T3–T5: as for ld.
  - T6: Gra, Rout, MDRin, with Read=0.
  - T7: Write.
  - Then →T0.
- add/sub/and/or:
  - T3: Grb, Rout, Yin.
  - T4: Grc, Rout, Zin, ALU_Control = ALU_ADD / ALU_SUB / ALU_AND / ALU_OR respectively.
  - T5: Zlowout, Gra, Rin.
  - Then →T0.
- addi: T3: Grb, Rout, Yin; T4: Cout, Zin, ALU_ADD; T5: Zlowout, Gra, Rin; then →T0.
- nop (and unknown opcodes): T2→T0 directly.
- halt: T2→HALT.
- HALT state: all outputs 0, Run=0. It is left only by clr.
- Stop: sampled on every edge whose next state would be T0. If Stop=1, go to HALT instead, so the current instruction always completes. Stop is ignored in the other states.
- Simultaneous clr and Stop: clr wins.
- Instruction lengths: ld/st 8 cycles; ldi/ALU/addi 6; nop 3.

Test Plan:
1. Release clr. Memory holds ld 0x00800075 at address 0 and 9 at address 0x75. The bench checks:
   - T0–T7 strobes exactly as specified;
   - PC=1 after T1;
   - R1=9 after T7;
   - 8 cycles until the next T0.
2. st 0x10800075 with R1=0x1234 → Write pulses exactly one cycle, in T7; Mem[0x75]=0x1234; Read=0 in T6.
3. add R3,R1,R2 (0x19890000) with R1=5, R2=7 → ALU_Control=2 only in T4; R3=12 after T5; back at T0 on cycle 6.
4. Unknown opcode 0xF8000000, then nop → no register or memory strobes after T2; PC advances by 1 per 3-cycle instruction.
5. Stop raised during T4 of an ld → the ld completes (R1 written in T7), then HALT; Run=0; outputs stay 0 for 20 cycles.
6. clr pulsed asynchronously mid-T6 of st → outputs 0 immediately; Write never asserts; the fetch sequence restarts at T0 one edge after clr falls.
